sent_tx_frame_ctrl: RTL
=======================

Name: sent_tx_frame_ctrl

Overview:
- Upstream sequencer for the SENT transmit pulse generator.
- Accepts a frame (status nibble plus data nibbles) over a valid/ready handshake and computes the SAE J2716 CRC-4.
- Drives one-hot pulse-type selects and the nibble value to the pulse generator, stepping on each pulse_done.
- Frame order: SYNC, STATUS, DATA[0..N-1], CRC, optional PAUSE; then the next frame back-to-back, or IDLE.

Parameters:
DATA_NIBBLES, 6, number of data nibbles per frame (legal 1..6); taken from data_i[23 -: 4*DATA_NIBBLES], most significant nibble first.

Ports:
clk_tx  in  1  transmit clock
reset_n_tx  in  1  asynchronous, active-low reset
enable_i  in  1  permit new frames to start
frame_valid_i  in  1  frame offered
frame_ready_o  out  1  frame accepted when valid&ready
status_i  in  4  status/communication nibble
data_i  in  24  data nibbles
pulse_done_i  in  1  one-cycle pulse from pulse generator, current pulse finished
data_nibble_o  out  4  nibble value for STATUS/DATA/CRC pulses
sync_o  out  1  select sync pulse
pulse_o  out  1  select nibble pulse
pause_o  out  1  select pause pulse
idle_o  out  1  select idle/stop signalling
crc_o  out  4  CRC of latched frame
frame_done_o  out  1  one-cycle pulse, last pulse of frame done

Behaviour:
- Reset, asynchronous: state RESET_IDLE; all outputs 0.
  - data_nibble_o=0, crc_o=0, all selects low, frame_ready_o=0.
- States: RESET_IDLE, SYNC, STATUS, DATA, CRC, PAUSE, IDLE.
  - RESET_IDLE is the same as IDLE except idle_o=0.
- Select outputs are registered and at most one is high at any time:
  - sync_o in SYNC; pulse_o in STATUS/DATA/CRC; pause_o in PAUSE; idle_o in IDLE.
- data_nibble_o is registered and stable for the whole state:
  - STATUS: status nibble.
  - DATA: nibble[idx].
  - CRC: crc.
  - SYNC/PAUSE/IDLE: 0.
- frame_ready_o is combinational and high when enable_i is high and either:
  - state is IDLE or RESET_IDLE; or
  - pulse_done_i is high in the last state (PAUSE, or CRC without the macro).
- Accept = frame_valid_i & frame_ready_o.
  - On accept: latch status and data, load crc, clear idx, go to SYNC on the next edge.
- Transitions, each on pulse_done_i (one step per pulse):
  - SYNC -> STATUS -> DATA.
  - DATA: idx+1; after idx==DATA_NIBBLES-1 -> CRC.
  - CRC -> PAUSE.
  - PAUSE -> SYNC if accept, else IDLE.
- frame_done_o pulses in the cycle after pulse_done_i of the last state.
- CRC: poly x^4+x^3+x^2+1, seed 4'b0101, computed over the data nibbles only (status excluded).
  - Per nibble: crc = T[crc] ^ nibble, where T[x] = (x·16) mod poly.
  - Then augment once: crc = T[crc].
  - Bitwise equivalent: shift data bits MSB-first into the low end; when the bit shifted out of bit3 is 1, XOR with 4'b1101.
  - Computed at accept; crc_o valid from the cycle after accept until the next accept.
- pulse_done_i is ignored in IDLE and RESET_IDLE.
- pulse_done_i coincident with accept in IDLE is ignored.
- enable_i low mid-frame: the current frame completes; the controller then enters IDLE.
- frame_valid_i while busy: not accepted (ready low), except at the end-of-frame point.
- Reset mid-frame: immediate return to RESET_IDLE; the partial frame is discarded.

Optional Feature:
SENT_TX_PAUSE_EN
- Defined: PAUSE state present; last state is PAUSE.
- Undefined: PAUSE state absent; CRC is the last state.
  - CRC pulse_done goes to SYNC on accept, else IDLE.
  - pause_o tied 0.

Test Plan:
- Single frame, status=0x3, data=0x000000, pulse_done_i every 20 cycles.
  - sync_o high, then pulse_o with nibbles 3,0,0,0,0,0,0,5, then pause_o (macro on), then idle_o.
  - crc_o=5; frame_done_o pulses once.
- Frame with data=0x000001.
  - crc_o=8; DATA sequence 0,0,0,0,0,1; CRC nibble 8.
- Back-to-back: second frame valid held during the first frame's last state.
  - ready/accept exactly at the last pulse_done.
  - SYNC follows directly; idle_o never asserted between frames.
- enable_i dropped during DATA idx=2.
  - Frame finishes through CRC/PAUSE, then IDLE; frame_ready_o stays 0 while enable low.
- reset_n_tx asserted during DATA.
  - All outputs 0 immediately.
  - After release, no select active until a new frame is accepted.
- Macro undefined, data=0xABCDEF.
  - pause_o never high; CRC is followed by IDLE.
  - frame_done_o pulses after the CRC pulse_done.

Source files
------------

// File: rtl/sent_tx_frame_ctrl_if.sv
// Frame handshake and pulse-generator select bundle for the SENT transmit frame controller.
// slave = frame controller, master = the frame source / pulse generator side.
interface sent_tx_frame_ctrl_if;
   logic        frame_valid_i;
   logic        frame_ready_o;
   logic [3:0]  status_i;
   logic [23:0] data_i;
   logic        pulse_done_i;
   logic [3:0]  data_nibble_o;
   logic        sync_o;
   logic        pulse_o;
   logic        pause_o;
   logic        idle_o;

   modport slave (
      input  frame_valid_i, status_i, data_i, pulse_done_i,
      output frame_ready_o, data_nibble_o, sync_o, pulse_o, pause_o, idle_o
   );

   modport master (
      output frame_valid_i, status_i, data_i, pulse_done_i,
      input  frame_ready_o, data_nibble_o, sync_o, pulse_o, pause_o, idle_o
   );
endinterface

// File: rtl/sent_tx_frame_ctrl.sv
// SENT frame sequencer: SYNC, STATUS, DATA[], CRC (+PAUSE when SENT_TX_PAUSE_EN is defined), one step per pulse_done.
// Selects/nibble registered; frame_ready_o is combinational so a queued frame is taken exactly at end of frame.
module sent_tx_frame_ctrl #(
   parameter int DATA_NIBBLES = 6
) (
   input  logic                     clk_tx,
   input  logic                     reset_n_tx,
   input  logic                     enable_i,
   sent_tx_frame_ctrl_if.slave      bus,
   output logic [3:0]               crc_o,
   output logic                     frame_done_o
);

   typedef enum logic [2:0] {
      RESET_IDLE,
      SYNC,
      STATUS,
      DATA,
      CRC,
      PAUSE,
      IDLE
   } state_t;

`ifdef SENT_TX_PAUSE_EN
   localparam state_t LAST_ST = PAUSE;
`else
   localparam state_t LAST_ST = CRC;
`endif

   localparam logic [2:0] IDX_LAST = 3'(DATA_NIBBLES - 1);

   // Multiply by x^4 modulo x^4+x^3+x^2+1, one bit at a time.
   function automatic logic [3:0] crc_mul16(input logic [3:0] x);
      logic [3:0] r;
      r = x;
      for (int b = 0; b < 4; b++) begin
         r = r[3] ? ({r[2:0], 1'b0} ^ 4'b1101) : {r[2:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [3:0] sent_crc(input logic [23:0] d);
      logic [3:0] r;
      r = 4'b0101;
      for (int k = 0; k < DATA_NIBBLES; k++) begin
         r = crc_mul16(r) ^ d[23 - 4*k -: 4];
      end
      return crc_mul16(r);
   endfunction

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  idx;
   logic [2:0]  idx_nxt;
   logic [3:0]  stat_q;
   logic [23:0] data_q;
   logic [3:0]  crc_q;
   logic [23:0] data_sh;
   logic [3:0]  nibble_nxt;
   logic        sync_nxt;
   logic        pulse_nxt;
   logic        idle_nxt;
   logic        sync_q;
   logic        pulse_q;
   logic        idle_q;
   logic [3:0]  nibble_q;
   logic        done_q;
   logic        is_idle;
   logic        last_done;
   logic        accept;

   assign is_idle   = (state == IDLE) || (state == RESET_IDLE);
   assign last_done = (state == LAST_ST) && bus.pulse_done_i;

   // Gated by reset so ready reads low while the block is held in reset.
   assign bus.frame_ready_o = reset_n_tx & enable_i & (is_idle | last_done);
   assign accept            = bus.frame_valid_i & bus.frame_ready_o;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         RESET_IDLE, IDLE: begin
            if (accept) begin
               state_nxt = SYNC;
               idx_nxt   = 3'd0;
            end
         end
         SYNC: begin
            if (bus.pulse_done_i) state_nxt = STATUS;
         end
         STATUS: begin
            if (bus.pulse_done_i) begin
               state_nxt = DATA;
               idx_nxt   = 3'd0;
            end
         end
         DATA: begin
            if (bus.pulse_done_i) begin
               if (idx == IDX_LAST) state_nxt = CRC;
               else                 idx_nxt   = idx + 3'd1;
            end
         end
`ifdef SENT_TX_PAUSE_EN
         CRC: begin
            if (bus.pulse_done_i) state_nxt = PAUSE;
         end
         PAUSE: begin
            if (bus.pulse_done_i) begin
               state_nxt = accept ? SYNC : IDLE;
               idx_nxt   = 3'd0;
            end
         end
`else
         CRC: begin
            if (bus.pulse_done_i) begin
               state_nxt = accept ? SYNC : IDLE;
               idx_nxt   = 3'd0;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase

      data_sh    = data_q << {idx_nxt, 2'b00};
      nibble_nxt = 4'd0;
      case (state_nxt)
         STATUS:  nibble_nxt = stat_q;
         DATA:    nibble_nxt = data_sh[23:20];
         CRC:     nibble_nxt = crc_q;
         default: nibble_nxt = 4'd0;
      endcase

      sync_nxt  = (state_nxt == SYNC);
      pulse_nxt = (state_nxt == STATUS) || (state_nxt == DATA) || (state_nxt == CRC);
      idle_nxt  = (state_nxt == IDLE);
   end

   always_ff @(posedge clk_tx or negedge reset_n_tx) begin
      if (!reset_n_tx) begin
         state    <= RESET_IDLE;
         idx      <= 3'd0;
         stat_q   <= 4'd0;
         data_q   <= 24'd0;
         crc_q    <= 4'd0;
         sync_q   <= 1'b0;
         pulse_q  <= 1'b0;
         idle_q   <= 1'b0;
         nibble_q <= 4'd0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         sync_q   <= sync_nxt;
         pulse_q  <= pulse_nxt;
         idle_q   <= idle_nxt;
         nibble_q <= nibble_nxt;
         done_q   <= last_done;
         if (accept) begin
            stat_q <= bus.status_i;
            data_q <= bus.data_i;
            crc_q  <= sent_crc(bus.data_i);
         end
      end
   end

`ifdef SENT_TX_PAUSE_EN
   logic pause_q;

   always_ff @(posedge clk_tx or negedge reset_n_tx) begin
      if (!reset_n_tx) pause_q <= 1'b0;
      else             pause_q <= (state_nxt == PAUSE);
   end

   assign bus.pause_o = pause_q;
`else
   assign bus.pause_o = 1'b0;
`endif

   assign bus.sync_o        = sync_q;
   assign bus.pulse_o       = pulse_q;
   assign bus.idle_o        = idle_q;
   assign bus.data_nibble_o = nibble_q;
   assign crc_o             = crc_q;
   assign frame_done_o      = done_q;

   a_sel_onehot : assert property (@(posedge clk_tx) disable iff (!reset_n_tx)
      $onehot0({bus.sync_o, bus.pulse_o, bus.pause_o, bus.idle_o}));

   a_ready_needs_enable : assert property (@(posedge clk_tx) disable iff (!reset_n_tx)
      !enable_i |-> !bus.frame_ready_o);

endmodule
